// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding and default load address for the program loader
package program_loader_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_t;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - little-endian byte-to-word accumulator for the program loader
module byte_word_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [7:0]            byte_data,
  output logic                  last_byte,
  output logic [DATA_WIDTH-1:0] word_next
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDX_W-1:0]      byte_idx;
  logic [DATA_WIDTH-1:0] word_q;

  assign last_byte = (byte_idx == IDX_W'(LANES - 1));

  // Word as it will look once the presented byte lands in its lane.
  always_comb begin
    word_next = word_q;
    for (int i = 0; i < LANES; i++) begin
      if (byte_idx == IDX_W'(i)) begin
        word_next[i*8 +: 8] = byte_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (accept) begin
      byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
      word_q   <= word_next;
    end
  end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a length-prefixed byte image into program memory while holding the core
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic                  Byte_Valid_i,
  input  logic [7:0]            Byte_Data_i,
  output logic                  Byte_Ready_o,
  output logic                  Write_Enable_o,
  output logic [DATA_WIDTH-1:0] Write_Address_o,
  output logic [DATA_WIDTH-1:0] Write_Data_o,
  output logic                  CPU_Hold_o,
  output logic                  Done_o,
  output logic                  Error_o
);

  localparam int                    WIDX   = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [15:0]           DEPTH  = 16'(MEMORY_DEPTH);
  localparam logic [DATA_WIDTH-1:0] BASE_W = DATA_WIDTH'(BASE_ADDRESS);

  state_t                state_q, state_d;
  logic [15:0]           count;
  logic [WIDX-1:0]       word_idx;
  logic                  accept;
  logic [15:0]           len_full;
  logic                  last_word;
  logic                  last_byte;
  logic [DATA_WIDTH-1:0] word_next;

  assign accept    = Byte_Valid_i && Byte_Ready_o;
  assign len_full  = {Byte_Data_i, count[7:0]};
  assign last_word = (16'(word_idx) == count - 16'd1);

  assign Byte_Ready_o   = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) || (state_q == ST_DATA);
  assign Write_Enable_o = (state_q == ST_WRITE);
  assign CPU_Hold_o     = (state_q != ST_DONE);
  assign Done_o         = (state_q == ST_DONE);
  assign Error_o        = (state_q == ST_ERROR);

  byte_word_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == ST_LEN_HI && accept),
    .accept    (state_q == ST_DATA && accept),
    .byte_data (Byte_Data_i),
    .last_byte (last_byte),
    .word_next (word_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Start_i) state_d = ST_LEN_LO;
      ST_LEN_LO: if (accept) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (len_full == 16'd0)    state_d = ST_DONE;
          else if (len_full > DEPTH) state_d = ST_ERROR;
          else                       state_d = ST_DATA;
        end
      end
      ST_DATA:   if (accept && last_byte) state_d = ST_WRITE;
      ST_WRITE:  state_d = last_word ? ST_DONE : ST_DATA;
      ST_DONE,
      ST_ERROR:  if (Start_i) state_d = ST_LEN_LO;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address and data are captured as the word completes so they are valid
  // throughout WRITE and then hold until the next word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count           <= '0;
      word_idx        <= '0;
      Write_Address_o <= '0;
      Write_Data_o    <= '0;
    end else begin
      case (state_q)
        ST_LEN_LO: if (accept) count[7:0] <= Byte_Data_i;
        ST_LEN_HI: begin
          if (accept) begin
            count[15:8] <= Byte_Data_i;
            word_idx    <= '0;
          end
        end
        ST_DATA: begin
          if (accept && last_byte) begin
            Write_Address_o <= BASE_W + (DATA_WIDTH'(word_idx) << 2);
            Write_Data_o    <= word_next;
          end
        end
        ST_WRITE:  if (!last_word) word_idx <= word_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader with directed byte images
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        Start_i = 1'b0;
  logic        Byte_Valid_i = 1'b0;
  logic [7:0]  Byte_Data_i = 8'h00;
  logic        Byte_Ready_o;
  logic        Write_Enable_o;
  logic [31:0] Write_Address_o;
  logic [31:0] Write_Data_o;
  logic        CPU_Hold_o;
  logic        Done_o;
  logic        Error_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[0:31];
  logic [31:0] last_addr = 32'h0;

  program_loader dut (
    .clk             (clk),
    .reset           (reset_n),
    .Start_i         (Start_i),
    .Byte_Valid_i    (Byte_Valid_i),
    .Byte_Data_i     (Byte_Data_i),
    .Byte_Ready_o    (Byte_Ready_o),
    .Write_Enable_o  (Write_Enable_o),
    .Write_Address_o (Write_Address_o),
    .Write_Data_o    (Write_Data_o),
    .CPU_Hold_o      (CPU_Hold_o),
    .Done_o          (Done_o),
    .Error_o         (Error_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (Write_Enable_o) begin
      check("ready_low_in_write", {31'b0, Byte_Ready_o}, 32'h0);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", Write_Address_o, 32'hFFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("write_addr", Write_Address_o, e[63:32]);
        check("write_data", Write_Data_o, e[31:0]);
        last_addr = Write_Address_o;
      end
    end
  end

  task automatic pulse_start();
    Start_i = 1'b1;
    @(negedge clk);
    Start_i = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit noise);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        Byte_Valid_i = 1'b0;
        Byte_Data_i  = 8'($urandom);
        @(negedge clk);
      end
    end
    Byte_Valid_i = 1'b1;
    Byte_Data_i  = b;
    Start_i      = noise;
    n = 0;
    while (!Byte_Ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("byte_accept_timeout", n, 0);
    @(negedge clk);
    Byte_Valid_i = 1'b0;
    Byte_Data_i  = 8'hEE;
    Start_i      = 1'b0;
  endtask

  task automatic load_image(input int nwords, input logic [15:0] len, input bit gaps, input bit noise);
    pulse_start();
    send_byte(len[7:0], gaps, 1'b0);
    send_byte(len[15:8], gaps, 1'b0);
    for (int w = 0; w < nwords; w++) begin
      exp_q.push_back({32'h0040_0000 + 32'(4 * w), img[w]});
      for (int b = 0; b < 4; b++) begin
        send_byte(img[w][8*b +: 8], gaps, noise && ((w + b) % 5 == 2) && (w != nwords - 1));
      end
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(Done_o || Error_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("end_reached", {31'b0, n < 100}, 32'h1);
  endtask

  task automatic check_status(input string tag, input bit done, input bit err, input bit hold);
    check({tag, "_done"}, {31'b0, Done_o}, {31'b0, done});
    check({tag, "_error"}, {31'b0, Error_o}, {31'b0, err});
    check({tag, "_hold"}, {31'b0, CPU_Hold_o}, {31'b0, hold});
    check({tag, "_sb_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hold", {31'b0, CPU_Hold_o}, 32'h1);
    check("rst_ready", {31'b0, Byte_Ready_o}, 32'h0);
    check("rst_we", {31'b0, Write_Enable_o}, 32'h0);
    check("rst_done_err", {30'b0, Done_o, Error_o}, 32'h0);
    check("rst_addr", Write_Address_o, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);

    // Normal two-word load.
    img[0] = 32'h00A0_0513;
    img[1] = 32'h00B0_0593;
    load_image(2, 16'd2, 1'b0, 1'b0);
    wait_end();
    check_status("normal", 1'b1, 1'b0, 1'b0);
    check("hold_addr", Write_Address_o, 32'h0040_0004);
    check("hold_data", Write_Data_o, 32'h00B0_0593);

    // Illegal length 33, then a legal reload from ERROR.
    load_image(0, 16'h0021, 1'b0, 1'b0);
    wait_end();
    check_status("illegal", 1'b0, 1'b1, 1'b1);
    check("error_ready", {31'b0, Byte_Ready_o}, 32'h0);
    img[0] = 32'h1122_3344;
    load_image(1, 16'd1, 1'b0, 1'b0);
    wait_end();
    check_status("reload", 1'b1, 1'b0, 1'b0);

    // Zero length.
    load_image(0, 16'd0, 1'b0, 1'b0);
    wait_end();
    check_status("zero", 1'b1, 1'b0, 1'b0);

    // Backpressure with random valid gaps.
    img[0] = 32'hDEAD_BEEF;
    img[1] = 32'h1234_5678;
    img[2] = 32'h0000_FFFF;
    load_image(3, 16'd3, 1'b1, 1'b0);
    wait_end();
    check_status("gaps", 1'b1, 1'b0, 1'b0);

    // Reset after two data bytes of a word, then a fresh load.
    pulse_start();
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'hEF, 1'b0, 1'b0);
    send_byte(8'hBE, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_hold", {31'b0, CPU_Hold_o}, 32'h1);
    check("midrst_ready", {31'b0, Byte_Ready_o}, 32'h0);
    check("midrst_addr", Write_Address_o, 32'h0);
    check("midrst_data", Write_Data_o, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    img[0] = 32'hCAFE_F00D;
    load_image(1, 16'd1, 1'b0, 1'b0);
    wait_end();
    check_status("after_rst", 1'b1, 1'b0, 1'b0);
    check("after_rst_addr", last_addr, 32'h0040_0000);

    // Full-depth load with Start_i pulses sprinkled in.
    for (int i = 0; i < 32; i++) img[i] = {8'(i), 8'hC3, 8'(~i), 8'h5A};
    load_image(32, 16'd32, 1'b0, 1'b1);
    wait_end();
    check_status("full", 1'b1, 1'b0, 1'b0);
    check("full_last_addr", last_addr, 32'h0040_007C);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
